// File: rtl/cbus_arbiter_pkg.sv
// Shared types for the core memory-bus arbiter: access sizes, arbiter states
// and the latched downstream request bundle.
package cbus_arbiter_pkg;

    localparam int CBUS_ADDR_W = 64;
    localparam int CBUS_DATA_W = 64;
    localparam int CBUS_STRB_W = CBUS_DATA_W / 8;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                   valid;
        logic                   write;
        logic [CBUS_ADDR_W-1:0] addr;
        msize_t                 size;
        logic [CBUS_STRB_W-1:0] strobe;
        logic [CBUS_DATA_W-1:0] wdata;
    } cbus_req_t;

    // Instructions are 32 bits; address bit 2 picks the half of the 64-bit beat.
    function automatic logic [31:0] fetch_word(input logic [CBUS_DATA_W-1:0] beat,
                                               input logic                   hi);
        return hi ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/cbus_arbiter.sv
// Shares the single cbus between instruction fetch and the data memory stage:
// one request latched at a time, round-robin on ties, response routed to the owner.
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                ireq_valid,
    input  logic [ADDR_W-1:0]   ireq_addr,
    output logic                i_data_ok,
    output logic [31:0]         i_data,

    input  logic                dreq_valid,
    input  logic                dreq_write,
    input  logic [ADDR_W-1:0]   dreq_addr,
    input  logic [2:0]          dreq_size,
    input  logic [DATA_W/8-1:0] dreq_strobe,
    input  logic [DATA_W-1:0]   dreq_wdata,
    output logic                d_data_ok,
    output logic [DATA_W-1:0]   d_data,

    output logic                oreq_valid,
    output logic                oreq_write,
    output logic [ADDR_W-1:0]   oreq_addr,
    output logic [2:0]          oreq_size,
    output logic [DATA_W/8-1:0] oreq_strobe,
    output logic [DATA_W-1:0]   oreq_wdata,
    input  logic                oresp_ok,
    input  logic [DATA_W-1:0]   oresp_data
);

    arb_state_t             state_q, state_d;
    cbus_req_t              req_q, req_d;
    logic                   last_d_q, last_d_d;
    logic                   grant_i, grant_d;
    logic [CBUS_DATA_W-1:0] beat;

    // last_d_q remembers who won the previous access; on a tie the other side wins.
    assign grant_d = dreq_valid & (~ireq_valid | ~last_d_q);
    assign grant_i = ireq_valid & (~dreq_valid |  last_d_q);

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        last_d_d = last_d_q;
        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    req_d.valid  = 1'b1;
                    req_d.write  = dreq_write;
                    req_d.addr   = CBUS_ADDR_W'(dreq_addr);
                    req_d.size   = msize_t'(dreq_size);
                    req_d.strobe = CBUS_STRB_W'(dreq_strobe);
                    req_d.wdata  = CBUS_DATA_W'(dreq_wdata);
                    state_d      = BUSY_D;
                    last_d_d     = 1'b1;
                end else if (grant_i) begin
                    req_d.valid  = 1'b1;
                    req_d.write  = 1'b0;
                    req_d.addr   = CBUS_ADDR_W'(ireq_addr);
                    req_d.size   = MSIZE4;
                    req_d.strobe = '0;
                    req_d.wdata  = '0;
                    state_d      = BUSY_I;
                    last_d_d     = 1'b0;
                end
            end
            BUSY_I, BUSY_D: begin
                // Completion always finishes downstream, even if the owner flushed.
                if (oresp_ok) begin
                    req_d.valid = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                req_d.valid = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            req_q    <= '0;
            last_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            last_d_q <= last_d_d;
        end
    end

    assign beat = CBUS_DATA_W'(oresp_data);

    assign i_data_ok = ~ireq_valid | ((state_q == BUSY_I) & oresp_ok);
    assign d_data_ok = ~dreq_valid | ((state_q == BUSY_D) & oresp_ok);
    assign i_data    = fetch_word(beat, req_q.addr[2]);
    assign d_data    = oresp_data;

    assign oreq_valid  = req_q.valid;
    assign oreq_write  = req_q.write;
    assign oreq_addr   = req_q.addr[ADDR_W-1:0];
    assign oreq_size   = req_q.size;
    assign oreq_strobe = req_q.strobe[DATA_W/8-1:0];
    assign oreq_wdata  = req_q.wdata[DATA_W-1:0];

endmodule
